// File: rtl/angle_cmd_ctrl_pkg.sv
// Shared types and default constants for the angle command controller.
// State encodings are fixed so state values seen on a debug bus match older captures.
package angle_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    WAIT_HI = 3'b001,
    WAIT_LO = 3'b010,
    PEND    = 3'b011,
    SEND    = 3'b100
  } state_t;

  localparam logic [3:0] DEF_HDR_TAG   = 4'hA;
  localparam logic [7:0] DEF_ACK_BYTE  = 8'hA5;
  localparam logic [7:0] DEF_NACK_BYTE = 8'h5A;

  // A first frame byte is usable only with clean parity and the expected tag nibble.
  function automatic logic header_ok(input logic [7:0] b, input logic perr,
                                     input logic [3:0] tag);
    return !perr && (b[7:4] == tag);
  endfunction

endpackage

// File: rtl/angle_cmd_ctrl_if.sv
// UART-facing byte bus of the angle command controller.
// master = UART side (receiver and transmitter), slave = controller.
interface angle_cmd_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       parity_error;
  logic       tx_busy;
  logic       start_tx;
  logic [7:0] data_to_tx;

  modport master (
    output rx_data, rx_done, parity_error, tx_busy,
    input  start_tx, data_to_tx
  );

  modport slave (
    input  rx_data, rx_done, parity_error, tx_busy,
    output start_tx, data_to_tx
  );
endinterface

// File: rtl/angle_cmd_ctrl_timer.sv
// Inter-byte timeout: reloadable down-counter, expired while running at zero.
// clear loads TIMEOUT_CYCLES-1 so expiry lands TIMEOUT_CYCLES cycles after the load edge.
module inter_byte_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 24000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     count <= '0;
    else if (clear)                count <= LOAD;
    else if (run && count != '0)   count <= count - W'(1);
  end

  assign expired = run && !clear && (count == '0);

endmodule

// File: rtl/angle_cmd_ctrl.sv
// Receive-side angle command controller: assembles two-byte frames, applies
// accepted angles on modulator period boundaries and answers with ACK/NACK.
module angle_cmd_ctrl
  import angle_cmd_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 24000,
  parameter int unsigned ANGLE_MAX      = 3600,
  parameter logic [3:0]  HDR_TAG        = DEF_HDR_TAG,
  parameter logic [7:0]  ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0]  NACK_BYTE      = DEF_NACK_BYTE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   period_sync,
  angle_cmd_ctrl_if.slave        bus,
  output logic [11:0]            angle,
  output logic                   angle_valid,
  output logic                   frame_err
);

  state_t      state, state_n;
  logic [3:0]  hi_nib, hi_n;
  logic [11:0] pend, pend_n, angle_n;
  logic [7:0]  reply, reply_n, tx_byte, tx_byte_n;
  logic        tx_start, tx_start_n, av_n, ferr_n;
  logic        hdr_ok, lo_ok, expired, tmr_clear, tmr_run;
  logic [11:0] lo_val;

  assign hdr_ok    = header_ok(bus.rx_data, bus.parity_error, HDR_TAG);
  assign lo_val    = {hi_nib, bus.rx_data};
  assign lo_ok     = !bus.parity_error && (32'(lo_val) < ANGLE_MAX);
  assign tmr_clear = enable && (state == WAIT_HI) && bus.rx_done && hdr_ok;
  assign tmr_run   = enable && (state == WAIT_LO);

  inter_byte_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .run     (tmr_run),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!enable) state_n = IDLE;
    else begin
      case (state)
        IDLE:    state_n = WAIT_HI;
        WAIT_HI: if (bus.rx_done && hdr_ok) state_n = WAIT_LO;
        // a byte arriving on the expiry cycle takes precedence over the timeout
        WAIT_LO: if (bus.rx_done)    state_n = lo_ok ? PEND : SEND;
                 else if (expired)   state_n = SEND;
        PEND:    if (period_sync)    state_n = SEND;
        SEND:    if (!bus.tx_busy)   state_n = WAIT_HI;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    hi_n       = hi_nib;
    pend_n     = pend;
    reply_n    = reply;
    angle_n    = angle;
    tx_byte_n  = tx_byte;
    tx_start_n = 1'b0;
    av_n       = 1'b0;
    ferr_n     = 1'b0;
    if (enable) begin
      case (state)
        WAIT_HI: if (bus.rx_done) begin
          if (hdr_ok) hi_n   = bus.rx_data[3:0];
          else        ferr_n = 1'b1;
        end
        WAIT_LO: if (bus.rx_done) begin
          if (lo_ok) pend_n = lo_val;
          else begin
            ferr_n  = 1'b1;
            reply_n = NACK_BYTE;
          end
        end else if (expired) begin
          ferr_n  = 1'b1;
          reply_n = NACK_BYTE;
        end
        // bytes arriving while a frame is still being applied or answered are dropped
        PEND: begin
          ferr_n = bus.rx_done;
          if (period_sync) begin
            angle_n = pend;
            av_n    = 1'b1;
            reply_n = ACK_BYTE;
          end
        end
        SEND: begin
          ferr_n = bus.rx_done;
          if (!bus.tx_busy) begin
            tx_start_n = 1'b1;
            tx_byte_n  = reply;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_nib      <= '0;
      pend        <= '0;
      reply       <= '0;
      angle       <= '0;
      tx_byte     <= '0;
      tx_start    <= 1'b0;
      angle_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      hi_nib      <= hi_n;
      pend        <= pend_n;
      reply       <= reply_n;
      angle       <= angle_n;
      tx_byte     <= tx_byte_n;
      tx_start    <= tx_start_n;
      angle_valid <= av_n;
      frame_err   <= ferr_n;
    end
  end

  assign bus.start_tx   = tx_start;
  assign bus.data_to_tx = tx_byte;

endmodule

// File: tb/tb_angle_cmd_ctrl.sv
// Self-checking bench for angle_cmd_ctrl: directed scenarios plus random frames
// judged by a frame-level outcome model (accept / NACK / silent drop).
module tb_angle_cmd_ctrl;

  localparam int unsigned T_OUT   = 24000;
  localparam int unsigned A_MAX   = 3600;
  localparam logic [7:0]  ACK_B   = 8'hA5;
  localparam logic [7:0]  NACK_B  = 8'h5A;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        period_sync;
  logic [11:0] angle;
  logic        angle_valid;
  logic        frame_err;

  angle_cmd_ctrl_if bus();

  angle_cmd_ctrl #(
    .TIMEOUT_CYCLES(T_OUT),
    .ANGLE_MAX     (A_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .period_sync (period_sync),
    .bus         (bus),
    .angle       (angle),
    .angle_valid (angle_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int n_tx = 0, n_ferr = 0, n_av = 0, n_misalign = 0, n_badchg = 0;
  int b_tx, b_ferr, b_av;
  logic [7:0]  last_tx = 8'h00;
  logic [11:0] prev_angle = 12'h000;
  logic [11:0] ref_angle = 12'h000;
  logic        ps_q = 1'b0;

  always @(posedge clk) ps_q <= period_sync;

  // Event recorder: counts output pulses and flags illegal angle activity.
  always @(negedge clk) begin
    if (bus.start_tx) begin
      n_tx++;
      last_tx = bus.data_to_tx;
    end
    if (frame_err) n_ferr++;
    if (angle_valid) begin
      n_av++;
      if (!ps_q) n_misalign++;
    end
    if (angle !== prev_angle && !angle_valid && !reset) n_badchg++;
    prev_angle = angle;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    b_tx = n_tx; b_ferr = n_ferr; b_av = n_av;
  endtask

  task automatic expect_d(input string tag, input int tx, input int ferr, input int av);
    check({tag, "_tx_count"},   32'(n_tx - b_tx),     32'(tx));
    check({tag, "_ferr_count"}, 32'(n_ferr - b_ferr), 32'(ferr));
    check({tag, "_av_count"},   32'(n_av - b_av),     32'(av));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic perr);
    bus.rx_data = b; bus.rx_done = 1'b1; bus.parity_error = perr;
    step(1);
    bus.rx_done = 1'b0; bus.parity_error = 1'b0;
  endtask

  task automatic pulse_sync();
    period_sync = 1'b1;
    step(1);
    period_sync = 1'b0;
  endtask

  task automatic wait_reply(input string tag, input logic [7:0] exp);
    int k = 0;
    while (n_tx <= b_tx && k < 200) begin
      step(1);
      k++;
    end
    check({tag, "_reply_seen"}, 32'(n_tx > b_tx), 32'd1);
    check({tag, "_reply_byte"}, 32'(last_tx), 32'(exp));
  endtask

  // Frame-level reference: header/parity fault -> silent drop; low-byte parity or
  // out-of-range -> NACK; otherwise the angle is applied at the next period_sync.
  task automatic do_frame(input string tag, input logic [11:0] v, input logic [3:0] hdr,
                          input logic p0, input logic p1, input logic overrun,
                          input int gap, input int sync_dly);
    logic [7:0] b1 = v[7:0];
    snap();
    send_byte({hdr, v[11:8]}, p0);
    if (p0 || hdr != 4'hA) begin
      step(6);
      expect_d(tag, 0, 1, 0);
      check({tag, "_angle"}, 32'(angle), 32'(ref_angle));
      return;
    end
    step(gap);
    send_byte(b1, p1);
    if (p1 || 32'(v) >= A_MAX) begin
      wait_reply(tag, NACK_B);
      step(3);
      expect_d(tag, 1, 1, 0);
    end else begin
      if (overrun) begin
        step(1);
        send_byte(8'($urandom), 1'b0);
      end
      step(sync_dly);
      pulse_sync();
      ref_angle = v;
      wait_reply(tag, ACK_B);
      step(3);
      expect_d(tag, 1, overrun ? 1 : 0, 1);
    end
    check({tag, "_angle"}, 32'(angle), 32'(ref_angle));
  endtask

  initial begin
    logic [11:0] rv;
    logic [3:0]  rh;
    reset = 1'b1; enable = 1'b0; period_sync = 1'b0;
    bus.rx_data = 8'h00; bus.rx_done = 1'b0; bus.parity_error = 1'b0; bus.tx_busy = 1'b0;
    step(2);
    check("rst_angle",       32'(angle),          32'd0);
    check("rst_angle_valid", 32'(angle_valid),    32'd0);
    check("rst_start_tx",    32'(bus.start_tx),   32'd0);
    check("rst_data_to_tx",  32'(bus.data_to_tx), 32'd0);
    check("rst_frame_err",   32'(frame_err),      32'd0);
    reset = 1'b0;
    step(1);
    enable = 1'b1;
    step(2);

    do_frame("valid",  12'h12C, 4'hA, 1'b0, 1'b0, 1'b0, 0, 50);
    do_frame("badhdr", 12'h1FF, 4'h3, 1'b0, 1'b0, 1'b0, 0, 0);
    do_frame("after_badhdr", 12'h010, 4'hA, 1'b0, 1'b0, 1'b0, 2, 5);
    do_frame("range_eq",  12'hE10, 4'hA, 1'b0, 1'b0, 1'b0, 0, 0);
    do_frame("range_max", 12'hE0F, 4'hA, 1'b0, 1'b0, 1'b0, 0, 3);

    // Timeout: NACK decision exactly T_OUT cycles after the first-byte edge
    snap();
    send_byte(8'hA1, 1'b0);
    step(T_OUT - 1);
    check("timeout_early", 32'(frame_err), 32'd0);
    step(1);
    check("timeout_edge", 32'(frame_err), 32'd1);
    wait_reply("timeout", NACK_B);
    step(3);
    expect_d("timeout", 1, 1, 0);
    check("timeout_angle", 32'(angle), 32'(ref_angle));
    do_frame("after_timeout", 12'h321, 4'hA, 1'b0, 1'b0, 1'b0, 1, 7);

    // Handshake hold with a dropped byte in SEND
    bus.tx_busy = 1'b1;
    snap();
    send_byte(8'hA3, 1'b0);
    send_byte(8'h00, 1'b0);
    step(4);
    pulse_sync();
    ref_angle = 12'h300;
    step(2);
    send_byte(8'hA7, 1'b0);
    step(10);
    expect_d("busy_hold", 0, 1, 1);
    check("busy_angle", 32'(angle), 32'h300);
    bus.tx_busy = 1'b0;
    wait_reply("busy_release", ACK_B);
    step(20);
    check("busy_single_pulse", 32'(n_tx - b_tx), 32'd1);

    // Reset while a frame is pending
    snap();
    send_byte(8'hA2, 1'b0);
    send_byte(8'h22, 1'b0);
    step(2);
    reset = 1'b1;
    #1;
    check("mid_rst_angle",      32'(angle),           32'd0);
    check("mid_rst_data_to_tx", 32'(bus.data_to_tx),  32'd0);
    check("mid_rst_start_tx",   32'(bus.start_tx),    32'd0);
    step(2);
    reset = 1'b0;
    ref_angle = 12'h000;
    step(2);
    pulse_sync();
    step(5);
    expect_d("pend_reset", 0, 0, 0);
    check("pend_reset_angle", 32'(angle), 32'd0);

    // Enable dropped in WAIT_LO discards the half frame
    snap();
    send_byte(8'hA1, 1'b0);
    step(1);
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    step(30);
    expect_d("en_drop", 0, 0, 0);
    send_byte(8'h2C, 1'b0);
    step(4);
    check("en_drop_resync_ferr", 32'(n_ferr - b_ferr), 32'd1);
    check("en_drop_no_reply",    32'(n_tx - b_tx),     32'd0);

    for (int i = 0; i < 40; i++) begin
      rv = 12'($urandom_range(0, 4095));
      rh = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 9)) : 4'hA;
      do_frame($sformatf("rnd%0d", i), rv, rh,
               1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 40)), int'($urandom_range(0, 60)));
    end

    check("av_aligned_to_sync", 32'(n_misalign), 32'd0);
    check("angle_stable",       32'(n_badchg),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
